shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter DW, default 32: datapath width.
REQ-002 Parameter SHIFT_WIDTH, default 5: shift-amount bits taken from data1[SHIFT_WIDTH-1:0].
REQ-003 The block SHALL have exactly one clock and an asynchronous, active-low reset: clk_i (input, 1, rising-edge clock); rst_ni (input, 1, async active-low reset).
REQ-004 req0_valid_i  input  1: requester 0 holds a valid shift request.
REQ-005 req0_ready_o  output 1: requester 0 request accepted this cycle.
REQ-006 req0_opcode_i  input  3, req0_data0_i  input  DW, req0_data1_i  input  DW: requester 0 opcode, operand and shift amount.
REQ-007 req1_valid_i, req1_ready_o, req1_opcode_i, req1_data0_i, req1_data1_i: same widths and meaning for requester 1.
REQ-008 rsp_valid_o  output 1: result register holds a valid result.
REQ-009 rsp_ready_i  input  1: consumer accepts the result.
REQ-010 rsp_id_o  output 1: index of the requester that owns the result.
REQ-011 rsp_result_o  output DW: shift result.

Function
REQ-012 The team shifter module (opcode[0]=SLL, else [1]=SRL, else [2]=SRA, else 0) SHALL be the sole shift datapath, instantiated once and shared by both requesters.
REQ-013 A transfer SHALL occur on reqN when reqN_valid_i && reqN_ready_o; at most one request SHALL be accepted per cycle.
REQ-014 can_accept = !rsp_valid_o || rsp_ready_i; no ready SHALL be asserted when can_accept is 0.
REQ-015 Grant SHALL be combinational from the current valids and the priority pointer; the ready of the ungranted requester SHALL be 0.
REQ-016 Accepted request SHALL be shifted and registered on the same edge; rsp_valid_o rises the cycle after acceptance (latency 1).
REQ-017 Output register states: EMPTY (rsp_valid_o=0) and FULL (rsp_valid_o=1); EMPTY->FULL on accept; FULL->EMPTY on rsp_ready_i with no accept; FULL->FULL with new data on simultaneous drain and accept (full throughput, one result per cycle).
REQ-018 While FULL and rsp_ready_i=0, rsp_result_o and rsp_id_o SHALL remain stable.
REQ-019 Only one requester valid: that requester SHALL be granted regardless of the pointer.
REQ-020 Shift amounts SHALL use data1[SHIFT_WIDTH-1:0] only; upper bits ignored; shift by 0 returns data0 unchanged.
REQ-021 Requesters SHALL hold valid and payload stable until accepted; the block SHALL NOT depend on stable payload before acceptance.
REQ-022 Opcode with multiple bits set SHALL resolve by priority [0]>[1]>[2]; opcode 3'b000 SHALL yield result 0 and still produce a response.

Reset
REQ-023 On rst_ni low, asynchronously: rsp_valid_o=0, rsp_result_o=0, rsp_id_o=0, priority pointer=0; req0_ready_o and req1_ready_o SHALL be 0 while reset is asserted.
REQ-024 Reset mid-operation SHALL discard any held result; no response SHALL appear for requests accepted before reset.
REQ-025 First grant after reset release with both valid SHALL go to requester 0.

Configuration
REQ-026 With SHIFT_ARB_ROUND_ROBIN_EN defined: on every accepted transfer the pointer SHALL move to the other requester; with both valid the pointed-to requester is granted.
REQ-027 Without SHIFT_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 always wins when both valid; the pointer register SHALL not exist.

Verification
REQ-028 Req0 only: SLL, data0=0x0000_0001, data1=0x0000_0004, rsp_ready=1 -> next cycle rsp_valid=1, result=0x0000_0010, id=0.
REQ-029 Req1 only: SRA, data0=0x8000_0000, data1=0xFFFF_FFE1 (amount 1) -> result=0xC000_0000, id=1.
REQ-030 Both valid every cycle, rsp_ready=1, RR_EN defined -> ids alternate 0,1,0,1 with one response per cycle; RR_EN undefined -> all ids 0, req1_ready stays 0.
REQ-031 Backpressure: rsp_ready=0 for 3 cycles while FULL -> both readys 0, result/id stable; rsp_ready=1 -> drain and accept in the same cycle, next result follows with no bubble.
REQ-032 Assert rst_ni low while FULL -> rsp_valid=0 and result=0 immediately (asynchronous); after release, both valid -> requester 0 granted first.
REQ-033 Opcode 3'b000 with data0=0xFFFF_FFFF -> response with result=0; opcode 3'b011 SRL/SLL conflict, data0=0x1, amount 1 -> result=0x2.

Source files
------------

// File: rtl/shift_arbiter.sv
// Two-requester shift arbiter: one shared shifter, a one-entry result register (EMPTY/FULL).
// Define SHIFT_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise requester 0 has fixed priority.

module shift_arbiter_shifter #(
   parameter int DW          = 32,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic [2:0]             op_i,
   input  logic [DW-1:0]          data_i,
   input  logic [SHIFT_WIDTH-1:0] amt_i,
   output logic [DW-1:0]          result_o
);
   // Opcode bits resolve by priority SLL > SRL > SRA; no bit set yields zero.
   always_comb begin
      result_o = '0;
      if (op_i[0])      result_o = data_i << amt_i;
      else if (op_i[1]) result_o = data_i >> amt_i;
      else if (op_i[2]) result_o = $signed(data_i) >>> amt_i;
   end
endmodule

module shift_arbiter #(
   parameter int DW          = 32,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          req0_valid_i,
   output logic          req0_ready_o,
   input  logic [2:0]    req0_opcode_i,
   input  logic [DW-1:0] req0_data0_i,
   input  logic [DW-1:0] req0_data1_i,
   input  logic          req1_valid_i,
   output logic          req1_ready_o,
   input  logic [2:0]    req1_opcode_i,
   input  logic [DW-1:0] req1_data0_i,
   input  logic [DW-1:0] req1_data1_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic          rsp_id_o,
   output logic [DW-1:0] rsp_result_o
);
   localparam logic ST_EMPTY = 1'b0;
   localparam logic ST_FULL  = 1'b1;

   // Handshake: a transfer happens on a port in any cycle where its valid and ready are both high.
   logic                   r_state;
   logic [DW-1:0]          r_result;
   logic                   r_id;
   logic                   w_can_accept;
   logic                   w_sel1;
   logic                   w_accept;
   logic [2:0]             w_opcode;
   logic [DW-1:0]          w_data0;
   logic [SHIFT_WIDTH-1:0] w_amt;
   logic [DW-1:0]          w_shift_result;
   logic                   w_unused_data1_hi;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
   logic r_ptr;
   assign w_sel1 = req1_valid_i && (!req0_valid_i || r_ptr);
`else
   assign w_sel1 = req1_valid_i && !req0_valid_i;
`endif

   assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready_i;
   // Gated by rst_ni so neither requester sees ready while reset is held.
   assign req0_ready_o = rst_ni && w_can_accept && req0_valid_i && !w_sel1;
   assign req1_ready_o = rst_ni && w_can_accept && w_sel1;
   assign w_accept     = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);

   assign w_opcode = w_sel1 ? req1_opcode_i : req0_opcode_i;
   assign w_data0  = w_sel1 ? req1_data0_i  : req0_data0_i;
   assign w_amt    = w_sel1 ? req1_data1_i[SHIFT_WIDTH-1:0] : req0_data1_i[SHIFT_WIDTH-1:0];
   assign w_unused_data1_hi = ^{req0_data1_i[DW-1:SHIFT_WIDTH], req1_data1_i[DW-1:SHIFT_WIDTH]};

   shift_arbiter_shifter #(
      .DW          (DW),
      .SHIFT_WIDTH (SHIFT_WIDTH)
   ) u_shifter (
      .op_i     (w_opcode),
      .data_i   (w_data0),
      .amt_i    (w_amt),
      .result_o (w_shift_result)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_EMPTY;
         r_result <= '0;
         r_id     <= 1'b0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_accept) begin
                  r_state  <= ST_FULL;
                  r_result <= w_shift_result;
                  r_id     <= w_sel1;
               end
            end
            default: begin
               if (w_accept) begin
                  r_result <= w_shift_result;
                  r_id     <= w_sel1;
               end else if (rsp_ready_i) begin
                  r_state <= ST_EMPTY;
               end
            end
         endcase
      end
   end

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
   // After each transfer the pointer favours the requester that was not just served.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)       r_ptr <= 1'b0;
      else if (w_accept) r_ptr <= !w_sel1;
   end
`endif

   assign rsp_valid_o  = (r_state == ST_FULL);
   assign rsp_result_o = r_result;
   assign rsp_id_o     = r_id;
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter; follows SHIFT_ARB_ROUND_ROBIN_EN like the DUT.
module tb_shift_arbiter;
  localparam int DW = 32;

  logic          clk;
  logic          rst_ni;
  logic          req0_valid, req0_ready;
  logic [2:0]    req0_opcode;
  logic [DW-1:0] req0_data0, req0_data1;
  logic          req1_valid, req1_ready;
  logic [2:0]    req1_opcode;
  logic [DW-1:0] req1_data0, req1_data1;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_result;

  int checks = 0;
  int errors = 0;

`ifdef SHIFT_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  shift_arbiter #(.DW(DW), .SHIFT_WIDTH(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready),
    .req0_opcode_i (req0_opcode),
    .req0_data0_i  (req0_data0),
    .req0_data1_i  (req0_data1),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready),
    .req1_opcode_i (req1_opcode),
    .req1_data0_i  (req1_data0),
    .req1_data1_i  (req1_data1),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_id_o      (rsp_id),
    .rsp_result_o  (rsp_result)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive_req0(input logic v, input logic [2:0] op, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req0_valid = v; req0_opcode = op; req0_data0 = d0; req0_data1 = d1;
  endtask

  task automatic drive_req1(input logic v, input logic [2:0] op, input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req1_valid = v; req1_opcode = op; req1_data0 = d0; req1_data1 = d1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    rsp_ready = 1'b0;
    drive_req0(1'b1, 3'b001, 32'h1, 32'h1);
    drive_req1(1'b1, 3'b001, 32'h1, 32'h1);
    #12;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", rsp_result); end
    checks++; if (rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got %0b exp 0", rsp_id); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b exp 00", req0_ready, req1_ready); end
    drive_req0(1'b0, 3'b000, 32'h0, 32'h0);
    drive_req1(1'b0, 3'b000, 32'h0, 32'h0);
    #10 rst_ni = 1'b1;
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_req0_sll();
    rsp_ready = 1'b1;
    drive_req0(1'b1, 3'b001, 32'h0000_0001, 32'h0000_0004);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL sll_ready got %0b%0b exp 10", req0_ready, req1_ready); end
    next_cycle();
    drive_req0(1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_0010 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL sll_rsp got v=%0b r=%h id=%0b exp v=1 r=00000010 id=0", rsp_valid, rsp_result, rsp_id); end
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sll_drain got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_req1_sra();
    rsp_ready = 1'b1;
    drive_req1(1'b1, 3'b100, 32'h8000_0000, 32'hFFFF_FFE1);
    #1;
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL sra_ready got %0b%0b exp 01", req0_ready, req1_ready); end
    next_cycle();
    drive_req1(1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hC000_0000 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL sra_rsp got v=%0b r=%h id=%0b exp v=1 r=c0000000 id=1", rsp_valid, rsp_result, rsp_id); end
    next_cycle();
  endtask

  task automatic test_both_valid();
    logic          exp_id;
    logic [DW-1:0] exp_res;
    rsp_ready = 1'b1;
    drive_req0(1'b1, 3'b001, 32'h0000_0001, 32'h0000_0001);  // -> 0x2
    drive_req1(1'b1, 3'b010, 32'h0000_0100, 32'h0000_0004);  // -> 0x10
    for (int k = 0; k < 4; k++) begin
      exp_id  = RR ? logic'(k % 2) : 1'b0;
      exp_res = exp_id ? 32'h0000_0010 : 32'h0000_0002;
      #1;
      checks++; if (req0_ready !== !exp_id || req1_ready !== exp_id) begin
        errors++; $display("FAIL both_ready[%0d] got %0b%0b exp %0b%0b", k, req0_ready, req1_ready, !exp_id, exp_id); end
      next_cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_res) begin
        errors++; $display("FAIL both_rsp[%0d] got v=%0b id=%0b r=%h exp v=1 id=%0b r=%h", k, rsp_valid, rsp_id, rsp_result, exp_id, exp_res); end
    end
    drive_req0(1'b0, 3'b000, 32'h0, 32'h0);
    drive_req1(1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL both_drain got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    logic          exp_id;
    logic [DW-1:0] exp_res;
    rsp_ready = 1'b1;
    drive_req0(1'b1, 3'b001, 32'h0000_0003, 32'h0000_0002);  // -> 0xC
    next_cycle();
    rsp_ready = 1'b0;
    drive_req0(1'b1, 3'b001, 32'h0000_0005, 32'h0000_0001);  // -> 0xA
    drive_req1(1'b1, 3'b010, 32'h0000_0080, 32'h0000_0003);  // -> 0x10
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready[%0d] got %0b%0b exp 00", k, req0_ready, req1_ready); end
      next_cycle();
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_000C || rsp_id !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%0b r=%h id=%0b exp v=1 r=0000000c id=0", k, rsp_valid, rsp_result, rsp_id); end
    end
    // The pointer moved to requester 1 when the 0xC request was taken.
    exp_id  = RR ? 1'b1 : 1'b0;
    exp_res = exp_id ? 32'h0000_0010 : 32'h0000_000A;
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== exp_id || req0_ready !== !exp_id) begin
      errors++; $display("FAIL bp_release_ready got %0b%0b exp %0b%0b", req0_ready, req1_ready, !exp_id, exp_id); end
    next_cycle();
    drive_req0(1'b0, 3'b000, 32'h0, 32'h0);
    drive_req1(1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_result !== exp_res) begin
      errors++; $display("FAIL bp_no_bubble got v=%0b id=%0b r=%h exp v=1 id=%0b r=%h", rsp_valid, rsp_id, rsp_result, exp_id, exp_res); end
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_opcode_edge();
    rsp_ready = 1'b1;
    drive_req0(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h0000_0003);
    next_cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0) begin
      errors++; $display("FAIL op000 got v=%0b r=%h exp v=1 r=00000000", rsp_valid, rsp_result); end
    drive_req0(1'b1, 3'b011, 32'h0000_0001, 32'h0000_0001);
    next_cycle();
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000_0002) begin
      errors++; $display("FAIL op011 got v=%0b r=%h exp v=1 r=00000002", rsp_valid, rsp_result); end
    drive_req0(1'b1, 3'b010, 32'hDEAD_BEEF, 32'h0000_0000);
    next_cycle();
    drive_req0(1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL shift0 got v=%0b r=%h exp v=1 r=deadbeef", rsp_valid, rsp_result); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    drive_req1(1'b1, 3'b100, 32'hF000_0000, 32'h0000_0004);  // -> 0xFF000000
    next_cycle();
    rsp_ready = 1'b0;
    drive_req1(1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'hFF00_0000 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL mid_fill got v=%0b r=%h id=%0b exp v=1 r=ff000000 id=1", rsp_valid, rsp_result, rsp_id); end
    #2 rst_ni = 1'b0;
    drive_req0(1'b1, 3'b001, 32'h1, 32'h1);
    drive_req1(1'b1, 3'b001, 32'h1, 32'h1);
    #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 32'h0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL mid_async got v=%0b r=%h id=%0b exp v=0 r=0 id=0", rsp_valid, rsp_result, rsp_id); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_ready got %0b%0b exp 00", req0_ready, req1_ready); end
    drive_req0(1'b0, 3'b000, 32'h0, 32'h0);
    drive_req1(1'b0, 3'b000, 32'h0, 32'h0);
    rsp_ready = 1'b1;
    next_cycle();
    #4 rst_ni = 1'b1;
    next_cycle();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale got %0b exp 0", rsp_valid); end
    drive_req0(1'b1, 3'b001, 32'h0000_0001, 32'h0000_0003);  // -> 0x8
    drive_req1(1'b1, 3'b010, 32'h0000_0010, 32'h0000_0001);  // -> 0x8
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL mid_first_grant got %0b%0b exp 10", req0_ready, req1_ready); end
    next_cycle();
    drive_req0(1'b0, 3'b000, 32'h0, 32'h0);
    drive_req1(1'b0, 3'b000, 32'h0, 32'h0);
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h0000_0008) begin
      errors++; $display("FAIL mid_first_rsp got v=%0b id=%0b r=%h exp v=1 id=0 r=00000008", rsp_valid, rsp_id, rsp_result); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_req0_sll();
    test_req1_sra();
    test_both_valid();
    test_backpressure();
    test_opcode_edge();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
